// File: rtl/bottle_fill_ctrl.sv
// Pill-bottling sequencer: latches a BCD setpoint, fills one bottle per cycle,
// indexes the conveyor and raises an end-of-batch alarm.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting; setpoint loads accepted here
// FILL  | valve open, pills counted by divider ticks
// PAUSE | run enable dropped mid-fill, all held
// SWAP  | conveyor indexing to the next bottle
// DONE  | single-bottle batch finished, alarm window
module bottle_fill_ctrl #(
  parameter int TICK_DIV     = 50,
  parameter int SWAP_CYCLES  = 100,
  parameter int ALARM_CYCLES = 200
) (
  input  logic        CLK_org,
  input  logic        RST,
  input  logic        isWork,
  input  logic        EN_set,
  input  logic [3:0]  set_high,
  input  logic [3:0]  set_low,
  input  logic        conti,
  output logic [7:0]  pill_cnt,
  output logic [11:0] bottle_cnt,
  output logic [7:0]  setpoint,
  output logic [2:0]  state,
  output logic        valve_open,
  output logic        conveyor_run,
  output logic        alarm,
  output logic        setpoint_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_SWAP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SWAP_LOAD  = SW'(SWAP_CYCLES - 1);
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES - 1);

  logic [DW-1:0] div_q, div_n;
  logic [SW-1:0] swap_tmr, swap_tmr_n;
  logic [AW-1:0] alarm_tmr, alarm_tmr_n;
  logic [2:0]    state_n;
  logic [7:0]    pill_n, setpoint_n, pill_inc;
  logic [11:0]   bottle_n, bottle_inc;
  logic          err_n, alarm_n, div_tc, load_ok;

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] >= 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = (v[11:8] >= 4'd9) ? 4'd0 : v[11:8] + 4'd1;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  assign pill_inc   = bcd2_inc(pill_cnt);
  assign bottle_inc = bcd3_inc(bottle_cnt);
  assign div_tc     = (div_q == DIV_LAST);
  assign load_ok    = (set_high <= 4'd9) && (set_low <= 4'd9) &&
                      ({set_high, set_low} != 8'h00);

  always_comb begin
    state_n     = state;
    pill_n      = pill_cnt;
    bottle_n    = bottle_cnt;
    setpoint_n  = setpoint;
    err_n       = setpoint_err;
    div_n       = div_q;
    swap_tmr_n  = swap_tmr;
    alarm_tmr_n = alarm_tmr;
    alarm_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (EN_set) begin
          if (load_ok) begin
            setpoint_n = {set_high, set_low};
            err_n      = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end else if (isWork) begin
          state_n = S_FILL;
          pill_n  = 8'h00;
          div_n   = '0;
        end
      end
      S_FILL: begin
        // the final pill of a bottle completes even if isWork drops on that cycle
        if (div_tc && (pill_inc == setpoint)) begin
          state_n    = S_SWAP;
          pill_n     = pill_inc;
          bottle_n   = bottle_inc;
          div_n      = '0;
          swap_tmr_n = SWAP_LOAD;
        end else if (!isWork) begin
          state_n = S_PAUSE;
        end else if (div_tc) begin
          div_n  = '0;
          pill_n = pill_inc;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (isWork) state_n = S_FILL;
      end
      S_SWAP: begin
        if (swap_tmr == '0) begin
          if (conti) begin
            state_n = S_FILL;
            pill_n  = 8'h00;
            div_n   = '0;
          end else begin
            state_n     = S_DONE;
            alarm_tmr_n = ALARM_LOAD;
            alarm_n     = 1'b1;
          end
        end else begin
          swap_tmr_n = swap_tmr - 1'b1;
        end
      end
      S_DONE: begin
        if (!isWork) begin
          state_n = S_IDLE;
        end else if (alarm_tmr != '0) begin
          alarm_tmr_n = alarm_tmr - 1'b1;
          alarm_n     = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Strobes are registered from the next-state decode so they line up with state.
  always_ff @(posedge CLK_org) begin
    if (RST) begin
      state        <= S_IDLE;
      pill_cnt     <= 8'h00;
      bottle_cnt   <= 12'h000;
      setpoint     <= 8'h10;
      setpoint_err <= 1'b0;
      div_q        <= '0;
      swap_tmr     <= '0;
      alarm_tmr    <= '0;
      valve_open   <= 1'b0;
      conveyor_run <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      state        <= state_n;
      pill_cnt     <= pill_n;
      bottle_cnt   <= bottle_n;
      setpoint     <= setpoint_n;
      setpoint_err <= err_n;
      div_q        <= div_n;
      swap_tmr     <= swap_tmr_n;
      alarm_tmr    <= alarm_tmr_n;
      valve_open   <= (state_n == S_FILL);
      conveyor_run <= (state_n == S_SWAP);
      alarm        <= alarm_n;
    end
  end

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Bench for bottle_fill_ctrl: integer-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bottle_fill_ctrl;
  localparam int TICK  = 4;
  localparam int SWAPC = 3;
  localparam int ALRM  = 5;

  logic        CLK_org, RST, isWork, EN_set, conti;
  logic [3:0]  set_high, set_low;
  logic [7:0]  pill_cnt, setpoint;
  logic [11:0] bottle_cnt;
  logic [2:0]  state;
  logic        valve_open, conveyor_run, alarm, setpoint_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  bottle_fill_ctrl #(.TICK_DIV(TICK), .SWAP_CYCLES(SWAPC), .ALARM_CYCLES(ALRM)) dut (
    .CLK_org(CLK_org), .RST(RST), .isWork(isWork), .EN_set(EN_set),
    .set_high(set_high), .set_low(set_low), .conti(conti),
    .pill_cnt(pill_cnt), .bottle_cnt(bottle_cnt), .setpoint(setpoint),
    .state(state), .valve_open(valve_open), .conveyor_run(conveyor_run),
    .alarm(alarm), .setpoint_err(setpoint_err)
  );

  initial begin
    CLK_org = 0;
    forever #5 CLK_org = ~CLK_org;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: plain decimal counts, phase ages counted up.
  int m_state, m_pills, m_bottles, m_sp, m_err, m_prog, m_age, m_hi, m_lo;

  function automatic int bcd2(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int bcd3(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  always @(posedge CLK_org) begin
    if (RST) begin
      m_state = 0; m_pills = 0; m_bottles = 0; m_sp = 10;
      m_err = 0; m_prog = 0; m_age = 0;
    end else begin
      case (m_state)
        0: begin
          if (EN_set) begin
            m_hi = int'(set_high);
            m_lo = int'(set_low);
            if (m_hi <= 9 && m_lo <= 9 && (m_hi * 10 + m_lo) != 0) begin
              m_sp = m_hi * 10 + m_lo;
              m_err = 0;
            end else m_err = 1;
          end else if (isWork) begin
            m_state = 1; m_pills = 0; m_prog = 0;
          end
        end
        1: begin
          if (m_prog == TICK - 1 && m_pills + 1 == m_sp) begin
            m_pills++;
            m_bottles = (m_bottles + 1) % 1000;
            m_state = 3; m_age = 0;
          end else if (!isWork) m_state = 2;
          else if (m_prog == TICK - 1) begin
            m_prog = 0; m_pills++;
          end else m_prog++;
        end
        2: if (isWork) m_state = 1;
        3: begin
          if (m_age == SWAPC - 1) begin
            if (conti) begin
              m_state = 1; m_pills = 0; m_prog = 0;
            end else begin
              m_state = 4; m_age = 0;
            end
          end else m_age++;
        end
        4: if (!isWork) m_state = 0; else if (m_age < 1000) m_age++;
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge CLK_org) begin
    if (chk_en) begin
      chk("model_state", int'(state), m_state);
      chk("model_pill", int'(pill_cnt), bcd2(m_pills));
      chk("model_bottle", int'(bottle_cnt), bcd3(m_bottles));
      chk("model_setpoint", int'(setpoint), bcd2(m_sp));
      chk("model_err", int'(setpoint_err), m_err);
      chk("model_valve", int'(valve_open), int'(m_state == 1));
      chk("model_conveyor", int'(conveyor_run), int'(m_state == 3));
      chk("model_alarm", int'(alarm), int'(m_state == 4 && m_age < ALRM));
    end
  end

  task automatic load(input logic [3:0] hi, input logic [3:0] lo);
    set_high = hi; set_low = lo; EN_set = 1;
    @(negedge CLK_org);
    EN_set = 0;
  endtask

  task automatic wait_state(input int s, input int bound, input string nm);
    int n = 0;
    while (int'(state) != s && n < bound) begin
      @(negedge CLK_org);
      n++;
    end
    chk(nm, int'(state), s);
  endtask

  initial begin
    int n;
    RST = 1; isWork = 0; EN_set = 0; conti = 0; set_high = 0; set_low = 0;
    repeat (2) @(negedge CLK_org);
    chk("rst_state", int'(state), 0);
    chk("rst_pill", int'(pill_cnt), 'h00);
    chk("rst_bottle", int'(bottle_cnt), 'h000);
    chk("rst_setpoint", int'(setpoint), 'h10);
    chk("rst_strobes", int'({valve_open, conveyor_run, alarm, setpoint_err}), 0);
    chk_en = 1;
    RST = 0;

    load(4'd0, 4'd3);
    chk("load03_sp", int'(setpoint), 'h03);
    chk("load03_err", int'(setpoint_err), 0);
    load(4'd0, 4'hA);
    chk("load0A_sp", int'(setpoint), 'h03);
    chk("load0A_err", int'(setpoint_err), 1);
    load(4'd0, 4'd0);
    chk("load00_err", int'(setpoint_err), 1);
    load(4'd1, 4'd2);
    chk("load12_sp", int'(setpoint), 'h12);
    chk("load12_err", int'(setpoint_err), 0);
    load(4'd0, 4'd3);

    // single bottle, setpoint 03
    conti = 0; isWork = 1;
    @(negedge CLK_org);
    chk("single_fill", int'(state), 1);
    n = 0;
    while (state == 3'd1 && n < 100) begin
      if (!valve_open) chk("single_valve", int'(valve_open), 1);
      n++;
      @(negedge CLK_org);
    end
    chk("single_fill_len", n, 12);
    chk("single_pill", int'(pill_cnt), 'h03);
    chk("single_bottle", int'(bottle_cnt), 'h001);
    n = 0;
    while (state == 3'd3 && n < 100) begin
      n++;
      @(negedge CLK_org);
    end
    chk("single_swap_len", n, 3);
    chk("single_done", int'(state), 4);
    n = 0;
    repeat (8) begin
      if (alarm) n++;
      @(negedge CLK_org);
    end
    chk("single_alarm_len", n, 5);
    isWork = 0;
    @(negedge CLK_org);
    chk("single_idle", int'(state), 0);
    chk("single_alarm_off", int'(alarm), 0);

    // continuous, setpoint 12, BCD carry
    load(4'd1, 4'd2);
    conti = 1; isWork = 1;
    n = 0;
    while (pill_cnt != 8'h09 && n < 200) begin
      n++;
      @(negedge CLK_org);
    end
    chk("cont_reach09", int'(pill_cnt), 'h09);
    n = 0;
    while (pill_cnt == 8'h09 && n < 20) begin
      n++;
      @(negedge CLK_org);
    end
    chk("cont_carry", int'(pill_cnt), 'h10);
    wait_state(3, 200, "cont_swap1");
    wait_state(1, 20, "cont_refill");
    chk("cont_restart_pill", int'(pill_cnt), 'h00);
    n = 0;
    while (state == 3'd1 && n < 200) begin
      n++;
      @(negedge CLK_org);
    end
    chk("cont_fill_len", n, 48);
    conti = 0;
    wait_state(4, 20, "cont_done");
    isWork = 0;
    @(negedge CLK_org);

    // pause two cycles into the second pill tick
    isWork = 1;
    @(negedge CLK_org);
    repeat (6) @(negedge CLK_org);
    chk("pause_pre_pill", int'(pill_cnt), 'h01);
    isWork = 0;
    @(negedge CLK_org);
    chk("pause_state", int'(state), 2);
    chk("pause_valve", int'(valve_open), 0);
    repeat (2) @(negedge CLK_org);
    chk("pause_hold_pill", int'(pill_cnt), 'h01);
    isWork = 1;
    @(negedge CLK_org);
    chk("pause_resume", int'(state), 1);
    n = 0;
    while (pill_cnt == 8'h01 && n < 20) begin
      n++;
      @(negedge CLK_org);
    end
    chk("pause_resume_lat", n, 2);
    wait_state(4, 300, "pause_done");
    isWork = 0;
    @(negedge CLK_org);
    chk("pause_bottle", int'(bottle_cnt), 'h004);

    // bottle counter wrap 999 -> 000
    load(4'd0, 4'd1);
    conti = 1; isWork = 1;
    n = 0;
    while (bottle_cnt != 12'h999 && n < 20000) begin
      n++;
      @(negedge CLK_org);
    end
    chk("wrap_reach999", int'(bottle_cnt), 'h999);
    n = 0;
    while (bottle_cnt == 12'h999 && n < 50) begin
      n++;
      @(negedge CLK_org);
    end
    chk("wrap_000", int'(bottle_cnt), 'h000);

    // reset during SWAP
    wait_state(3, 20, "rst_swap_entry");
    RST = 1;
    @(negedge CLK_org);
    chk("midrst_state", int'(state), 0);
    chk("midrst_conveyor", int'(conveyor_run), 0);
    chk("midrst_bottle", int'(bottle_cnt), 'h000);
    chk("midrst_setpoint", int'(setpoint), 'h10);
    RST = 0; isWork = 0; conti = 0;
    repeat (3) @(negedge CLK_org);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
